// File: rtl/mult_operand_sequencer.sv
// Operand stage for a shift-add multiplier: latches one m/M pair and issues one
// pre-shifted, pre-gated addend per multiplier bit, LSB first, over valid/ready.
module mult_operand_sequencer #(
    parameter int WIDTH     = 3,
    parameter bit SKIP_ZERO = 1'b0,
    localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_M,
    output logic               step_valid,
    input  logic               step_ready,
    output logic               step_bit,
    output logic [2*WIDTH-1:0] step_addend,
    output logic [CW-1:0]      step_idx,
    output logic               step_last,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mult_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [CW-1:0]      idx;
    logic [CW-1:0]      idx_nxt;
    logic [2*WIDTH-1:0] in_mcand;

    function automatic logic bit_at(input logic [WIDTH-1:0] m, input logic [CW-1:0] i);
        logic [WIDTH-1:0] sh;
        sh = m >> i;
        return sh[0];
    endfunction

    function automatic logic [2*WIDTH-1:0] addend_at(input logic [WIDTH-1:0]   m,
                                                      input logic [2*WIDTH-1:0] mc,
                                                      input logic [CW-1:0]      i);
        return bit_at(m, i) ? (mc << i) : '0;
    endfunction

    // The extra top bit keeps the "bits above i" test well defined at i = WIDTH-1.
    function automatic logic last_at(input logic [WIDTH-1:0] m, input logic [CW-1:0] i);
        logic [WIDTH:0] rest;
        rest = ({1'b0, m} >> i) >> 1;
        return (i == CW'(WIDTH - 1)) || (SKIP_ZERO && (rest == '0));
    endfunction

    assign idx_nxt  = idx + 1'b1;
    assign in_mcand = {{WIDTH{1'b0}}, in_M};
    assign step_idx = idx;
    assign in_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mult_reg    <= '0;
            mcand_reg   <= '0;
            idx         <= '0;
            step_valid  <= 1'b0;
            step_bit    <= 1'b0;
            step_addend <= '0;
            step_last   <= 1'b0;
            busy        <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                // First step's outputs are loaded on the accept edge itself.
                state       <= ISSUE;
                mult_reg    <= in_m;
                mcand_reg   <= in_mcand;
                idx         <= '0;
                step_valid  <= 1'b1;
                busy        <= 1'b1;
                step_bit    <= bit_at(in_m, '0);
                step_addend <= addend_at(in_m, in_mcand, '0);
                step_last   <= last_at(in_m, '0);
            end
        end else if (step_ready) begin
            if (step_last) begin
                state       <= IDLE;
                idx         <= '0;
                step_valid  <= 1'b0;
                busy        <= 1'b0;
                step_bit    <= 1'b0;
                step_addend <= '0;
                step_last   <= 1'b0;
            end else begin
                idx         <= idx_nxt;
                step_bit    <= bit_at(mult_reg, idx_nxt);
                step_addend <= addend_at(mult_reg, mcand_reg, idx_nxt);
                step_last   <= last_at(mult_reg, idx_nxt);
            end
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Bench for mult_operand_sequencer: two instances (SKIP_ZERO 0 and 1) checked
// every cycle against an arithmetic step model plus directed literal expectations.
module tb_mult_operand_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       in_valid;
    logic [2:0] in_m;
    logic [2:0] in_M;
    logic       step_ready;

    logic       in_ready_a, step_valid_a, step_bit_a, step_last_a, busy_a;
    logic [5:0] step_addend_a;
    logic [1:0] step_idx_a;
    logic       in_ready_b, step_valid_b, step_bit_b, step_last_b, busy_b;
    logic [5:0] step_addend_b;
    logic [1:0] step_idx_b;

    logic       in_valid_a, in_valid_b;
    logic       in_ready, step_valid, step_bit, step_last, busy;
    logic [5:0] step_addend;
    logic [1:0] step_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign in_valid_a  = in_valid && !sel;
    assign in_valid_b  = in_valid && sel;
    assign in_ready    = sel ? in_ready_b    : in_ready_a;
    assign step_valid  = sel ? step_valid_b  : step_valid_a;
    assign step_bit    = sel ? step_bit_b    : step_bit_a;
    assign step_addend = sel ? step_addend_b : step_addend_a;
    assign step_idx    = sel ? step_idx_b    : step_idx_a;
    assign step_last   = sel ? step_last_b   : step_last_a;
    assign busy        = sel ? busy_b        : busy_a;

    mult_operand_sequencer #(.WIDTH(3), .SKIP_ZERO(1'b0)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_m(in_m), .in_M(in_M), .step_valid(step_valid_a), .step_ready(step_ready),
        .step_bit(step_bit_a), .step_addend(step_addend_a), .step_idx(step_idx_a),
        .step_last(step_last_a), .busy(busy_a)
    );

    mult_operand_sequencer #(.WIDTH(3), .SKIP_ZERO(1'b1)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_m(in_m), .in_M(in_M), .step_valid(step_valid_b), .step_ready(step_ready),
        .step_bit(step_bit_b), .step_addend(step_addend_b), .step_idx(step_idx_b),
        .step_last(step_last_b), .busy(busy_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] pk(input int b, input int a, input int i, input int l);
        logic [9:0] r;
        r = {b[0], a[5:0], i[1:0], l[0]};
        return r;
    endfunction

    // Model: a pair is a list of steps k = 0..count-1, bit k of m gating M*2^k.
    int mbusy = 0;
    int mk    = 0;
    int mcnt  = 0;
    int mm    = 0;
    int mM    = 0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mbusy = 0;
                mk    = 0;
            end else if (mbusy != 0) begin
                if (step_ready) begin
                    mk++;
                    if (mk == mcnt) mbusy = 0;
                end
            end else if (in_valid) begin
                mm   = int'(in_m);
                mM   = int'(in_M);
                mk   = 0;
                mbusy = 1;
                if (sel) begin
                    mcnt = 1;
                    for (int i = 0; i < 3; i++) if (((mm >> i) & 1) == 1) mcnt = i + 1;
                end else begin
                    mcnt = 3;
                end
            end
        end
    end

    logic [9:0] log_q[$];
    int         logn_q[$];
    int         ncyc = 0;
    int         sum  = 0;

    initial begin
        int eb, ea;
        forever begin
            @(negedge clk);
            chk("in_ready", int'(in_ready), (mbusy == 0 && !reset) ? 1 : 0);
            chk("step_valid", int'(step_valid), mbusy);
            chk("busy", int'(busy), mbusy);
            if (reset) begin
                chk("reset_step_fields", pk(step_bit, step_addend, step_idx, step_last), 0);
                sum = 0;
            end
            if (mbusy != 0) begin
                eb = (mm >> mk) & 1;
                ea = (eb == 1) ? (mM << mk) : 0;
                chk("step_bit", int'(step_bit), eb);
                chk("step_addend", int'(step_addend), ea);
                chk("step_idx", int'(step_idx), mk);
                chk("step_last", int'(step_last), (mk == mcnt - 1) ? 1 : 0);
            end
            if (step_valid && step_ready && !reset) begin
                log_q.push_back(pk(step_bit, step_addend, step_idx, step_last));
                logn_q.push_back(ncyc);
                sum += int'(step_addend);
                if (step_last) begin
                    chk("addend_sum", sum, mm * mM);
                    sum = 0;
                end
            end
            ncyc++;
        end
    end

    task automatic send(input logic [2:0] m, input logic [2:0] mc);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", int'(in_ready), 1);
        in_m     = m;
        in_M     = mc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic chk_log(input string nm, input int j, input logic [9:0] exp);
        if (j < log_q.size()) chk(nm, int'(log_q[j]), int'(exp));
        else chk({nm, "_missing"}, log_q.size(), j + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n;
        reset = 1'b1; sel = 1'b0; in_valid = 1'b0; in_m = '0; in_M = '0; step_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Basic sequence
        log_q.delete(); logn_q.delete();
        send(3'b101, 3'b011);
        wait_idle();
        chk("basic_ready_after", int'(in_ready), 1);
        chk("basic_count", log_q.size(), 3);
        chk_log("basic0", 0, pk(1, 3, 0, 0));
        chk_log("basic1", 1, pk(0, 0, 1, 0));
        chk_log("basic2", 2, pk(1, 12, 2, 1));

        // Backpressure at idx 1
        log_q.delete(); logn_q.delete();
        send(3'b111, 3'b111);
        @(posedge clk); #1;
        step_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold", int'(pk(step_bit, step_addend, step_idx, step_last)), int'(pk(1, 14, 1, 0)));
            @(posedge clk); #1;
        end
        chk("bp_hold_valid", int'(step_valid), 1);
        step_ready = 1'b1;
        wait_idle();
        chk("bp_count", log_q.size(), 3);
        chk_log("bp0", 0, pk(1, 7, 0, 0));
        chk_log("bp1", 1, pk(1, 14, 1, 0));
        chk_log("bp2", 2, pk(1, 28, 2, 1));
        s = 0;
        foreach (log_q[i]) s += int'(log_q[i][8:3]);
        chk("bp_sum", s, 49);

        // Zero multiplier, no skipping
        log_q.delete(); logn_q.delete();
        send(3'b000, 3'b101);
        wait_idle();
        chk("zero_count", log_q.size(), 3);
        chk_log("zero0", 0, pk(0, 0, 0, 0));
        chk_log("zero1", 1, pk(0, 0, 1, 0));
        chk_log("zero2", 2, pk(0, 0, 2, 1));

        // Early termination on the SKIP_ZERO instance
        sel = 1'b1;
        @(posedge clk); #1;
        log_q.delete(); logn_q.delete();
        send(3'b001, 3'b111);
        wait_idle();
        chk("skip1_count", log_q.size(), 1);
        chk_log("skip1", 0, pk(1, 7, 0, 1));
        log_q.delete(); logn_q.delete();
        send(3'b000, 3'b111);
        wait_idle();
        chk("skip0_count", log_q.size(), 1);
        chk_log("skip0", 0, pk(0, 0, 0, 1));
        log_q.delete(); logn_q.delete();
        send(3'b010, 3'b011);
        wait_idle();
        chk("skip2_count", log_q.size(), 2);
        chk_log("skip2_last", 1, pk(1, 6, 1, 1));
        sel = 1'b0;
        @(posedge clk); #1;

        // in_valid held high with changing data during ISSUE
        log_q.delete(); logn_q.delete();
        in_m = 3'd6; in_M = 3'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!(step_valid && step_last) && n < 20) begin
            in_m = 3'($urandom);
            in_M = 3'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_m = 3'd1; in_M = 3'd2;
        @(posedge clk); #1;
        chk("hs_ready_after_last", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hs_first_valid", int'(step_valid), 1);
        wait_idle();
        chk("hs_count", log_q.size(), 6);
        chk_log("hs0", 0, pk(0, 0, 0, 0));
        chk_log("hs1", 1, pk(1, 10, 1, 0));
        chk_log("hs2", 2, pk(1, 20, 2, 1));
        chk_log("hs3", 3, pk(1, 2, 0, 0));
        chk_log("hs4", 4, pk(0, 0, 1, 0));
        chk_log("hs5", 5, pk(0, 0, 2, 1));
        if (logn_q.size() >= 4) chk("hs_gap", logn_q[3] - logn_q[2], 2);
        else chk("hs_gap_missing", logn_q.size(), 4);

        // Reset mid-sequence
        send(3'b111, 3'b011);
        @(posedge clk); #1;
        chk("rst_at_idx1", int'(step_idx), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", int'(step_valid), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_release_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_steps", int'(step_valid), 0);
        log_q.delete(); logn_q.delete();
        send(3'b010, 3'b101);
        wait_idle();
        chk("rst_count", log_q.size(), 3);
        chk_log("rst0", 0, pk(0, 0, 0, 0));
        chk_log("rst1", 1, pk(1, 10, 1, 0));
        chk_log("rst2", 2, pk(0, 0, 2, 1));

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
